block_dematrix_48: RTL and testbench
====================================

Name: block_dematrix_48

Overview:
- Stereo de-matrix stage for the receive/verification path. It is the inverse of the L+R / L−R matrix stage.
- Accepts independently strobed 18-bit signed LpR and LmR samples and pairs them.
- Computes LEFT = (LpR+LmR)·G/8 and RIGHT = (LpR−LmR)·G/8, with round-half-up and 18-bit saturation.
- Uses one time-multiplexed sequential shift-add multiplier. Emits both channels with a single-cycle ready pulse.

Parameters:
- W, 18, sample width (signed).
- GW, 4, gain width (unsigned).
- SHIFT, 3, post-multiply right shift (gain LSB = 1/8).

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- LpR_in  in  18  signed L+R sample
- LpR_valid  in  1  1-cycle strobe, LpR_in valid
- LmR_in  in  18  signed L−R sample
- LmR_valid  in  1  1-cycle strobe, LmR_in valid
- G  in  4  unsigned gain, sampled at pair capture
- LEFT  out  18  signed left output, registered
- RIGHT  out  18  signed right output, registered
- ready_out  out  1  1-cycle pulse, LEFT/RIGHT updated
- overrun  out  1  1-cycle pulse, buffered sample overwritten
- busy  out  1  high while the FSM is not IDLE

Behaviour:

Reset:
- All outputs 0.
- Capture registers empty; FSM IDLE.
- Reset mid-computation aborts it; no ready_out is produced.

Capture:
- Each channel has a holding register plus a full flag.
- A valid strobe loads the register and sets its flag.
- A valid strobe while the flag is already set overwrites the register and pulses overrun on the next cycle.
- Both valids in the same cycle are legal.

Pair start (edge 0):
- Condition: both flags set and FSM IDLE.
- Copy both samples and G into working registers and clear both flags. New samples may be accepted during computation.
- Working sums are 19-bit signed:
  - S_L = LpR+LmR
  - S_R = LpR−LmR

FSM:
- IDLE → MUL_L: edges 1–4, one gain bit per edge, LSB first, shift-add into a 23-bit signed accumulator.
- MUL_L → MUL_R: edges 5–8, same procedure on S_R.
- MUL_R → OUT: edge 9 registers LEFT and RIGHT and asserts ready_out for exactly one cycle.
- OUT → IDLE, or directly into a new pair start if both flags are set.
- Fixed latency: ready_out goes high after the 9th edge following the completing capture edge.

Arithmetic:
- p = S·G (23-bit signed).
- q = (p + 4) >>> 3 (arithmetic shift; round half toward +∞).
- Saturate q to [−131072, 131071].
- G = 0 gives an output of 0.

Outputs:
- LEFT and RIGHT hold their value until the next OUT.
- busy = (state ≠ IDLE).

Decomposition:
- Package dematrix_pkg:
  - W, GW, SHIFT
  - SAT_MAX = 131071, SAT_MIN = −131072
  - ROUND_K = 4
  - state enum {IDLE, MUL_L, MUL_R, OUT}
  - saturation function
- Sub-module seq_shift_add_mult:
  - 19×4 signed×unsigned, start/done handshake, 4-cycle fixed latency.
  - Instantiated once and shared between L and R.

Test Plan:
1. Reset, then LpR=1000 and LmR=200 in the same cycle, G=8 → 9 cycles later ready_out=1 for one cycle; LEFT=1200, RIGHT=800; busy high for cycles 1–9.
2. LpR=131071 then LmR=131071 three cycles later, G=15 → LEFT=131071 (saturated), RIGHT=0; latency counted from the LmR edge.
3. LpR=−131072, LmR=131071, G=8 → LEFT=−1, RIGHT=−131072 (saturated).
4. Rounding, G=3:
   - LpR=5, LmR=0 → LEFT=2, RIGHT=2.
   - LpR=−5, LmR=0 → LEFT=−2, RIGHT=−2.
5. LpR valid twice (values 10, 20) before LmR=0, G=8 → overrun pulse after the 2nd strobe; outputs LEFT=20, RIGHT=20.
6. New pair presented at cycle 3 of a running computation → first result completes unaffected; second pair starts at OUT; second ready_out exactly 10 cycles after the first. Reset asserted at cycle 5 of a computation → no ready_out, outputs 0, busy=0.

Source files
------------

// File: rtl/dematrix_pkg.sv
// Shared constants, FSM state type and round/saturate helper for the stereo de-matrix stage.
`timescale 1ns/1ps
package dematrix_pkg;
    localparam int W       = 18;
    localparam int GW      = 4;
    localparam int SHIFT   = 3;
    localparam int SW      = W + 1;
    localparam int PW      = 23;
    localparam int SAT_MAX = 131071;
    localparam int SAT_MIN = -131072;
    localparam int ROUND_K = 4;

    typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, OUT} state_t;

    // Round half toward +inf, drop the gain fraction, clamp to the sample range.
    function automatic logic signed [W-1:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        q = (p + PW'(ROUND_K)) >>> SHIFT;
        if (q > PW'(SAT_MAX))
            return W'(SAT_MAX);
        else if (q < PW'(SAT_MIN))
            return W'(SAT_MIN);
        else
            return q[W-1:0];
    endfunction
endpackage

// File: rtl/seq_shift_add_mult.sv
// Signed x unsigned shift-add multiplier, one gain bit per cycle, LSB first.
`timescale 1ns/1ps
module seq_shift_add_mult
    import dematrix_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [SW-1:0] a,
    input  logic        [GW-1:0] b,
    output logic signed [PW-1:0] product,
    output logic                 running,
    output logic                 done
);
    localparam int CW = $clog2(GW);

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] m;
    logic        [GW-1:0] g;
    logic        [CW-1:0] cnt;

    assign a_ext = PW'(a);

    // The start cycle already consumes bit 0, so the product is final after GW edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            product <= '0;
            m       <= '0;
            g       <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= b[0] ? a_ext : '0;
                m       <= a_ext <<< 1;
                g       <= b >> 1;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                if (g[0])
                    product <= product + m;
                m   <= m <<< 1;
                g   <= g >> 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(GW - 2)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/block_dematrix_48.sv
// Stereo de-matrix: pairs strobed L+R / L-R samples and emits gained LEFT/RIGHT
// through one shared sequential multiplier.
`timescale 1ns/1ps
module block_dematrix_48
    import dematrix_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic signed [W-1:0] LpR_in,
    input  logic                LpR_valid,
    input  logic signed [W-1:0] LmR_in,
    input  logic                LmR_valid,
    input  logic       [GW-1:0] G,
    output logic signed [W-1:0] LEFT,
    output logic signed [W-1:0] RIGHT,
    output logic                ready_out,
    output logic                overrun,
    output logic                busy
);
    // state | meaning
    // IDLE  | waiting for both holding registers to fill
    // MUL_L | multiplier working on S_L = LpR + LmR
    // MUL_R | multiplier working on S_R = LpR - LmR
    // OUT   | LEFT/RIGHT just updated, ready_out high
    state_t state, state_next;

    logic signed [W-1:0]  reg_p, reg_m, eff_p, eff_m;
    logic                 full_p, full_m, have_p, have_m;
    logic                 pair_start;
    logic signed [SW-1:0] s_l, s_r, mul_a;
    logic        [GW-1:0] g_work;
    logic signed [PW-1:0] p_l, mul_product;
    logic                 mul_start, mul_running, mul_done;

    // A strobe on the completing edge counts immediately, so the pair starts on that edge.
    assign have_p     = full_p | LpR_valid;
    assign have_m     = full_m | LmR_valid;
    assign eff_p      = LpR_valid ? LpR_in : reg_p;
    assign eff_m      = LmR_valid ? LmR_in : reg_m;
    assign pair_start = have_p & have_m & ((state == IDLE) | (state == OUT));

    assign mul_start = (state == MUL_L) & ~mul_running;
    assign mul_a     = mul_done ? s_r : s_l;
    assign busy      = (state != IDLE);

    seq_shift_add_mult u_mult (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (mul_a),
        .b       (g_work),
        .product (mul_product),
        .running (mul_running),
        .done    (mul_done)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pair_start) state_next = MUL_L;
            MUL_L:   if (mul_done) state_next = MUL_R;
            MUL_R:   if (mul_done) state_next = OUT;
            OUT:     state_next = pair_start ? MUL_L : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            reg_p     <= '0;
            reg_m     <= '0;
            full_p    <= 1'b0;
            full_m    <= 1'b0;
            s_l       <= '0;
            s_r       <= '0;
            g_work    <= '0;
            p_l       <= '0;
            LEFT      <= '0;
            RIGHT     <= '0;
            ready_out <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= (LpR_valid & full_p) | (LmR_valid & full_m);
            if (LpR_valid)
                reg_p <= LpR_in;
            if (LmR_valid)
                reg_m <= LmR_in;
            if (pair_start) begin
                full_p <= 1'b0;
                full_m <= 1'b0;
                s_l    <= SW'(eff_p) + SW'(eff_m);
                s_r    <= SW'(eff_p) - SW'(eff_m);
                g_work <= G;
            end else begin
                if (LpR_valid)
                    full_p <= 1'b1;
                if (LmR_valid)
                    full_m <= 1'b1;
            end
            if ((state == MUL_L) && mul_done)
                p_l <= mul_product;
            ready_out <= (state == MUL_R) && mul_done;
            if ((state == MUL_R) && mul_done) begin
                LEFT  <= round_sat(p_l);
                RIGHT <= round_sat(mul_product);
            end
        end
    end
endmodule

// File: tb/tb_block_dematrix_48.sv
// Directed bench for block_dematrix_48: vector table plus hand sequences for
// split strobes, overrun, back-to-back pairs and mid-computation reset.
`timescale 1ns/1ps
module tb_block_dematrix_48;
    logic               clock = 1'b0;
    logic               reset;
    logic signed [17:0] LpR_in, LmR_in;
    logic               LpR_valid, LmR_valid;
    logic        [3:0]  G;
    logic signed [17:0] LEFT, RIGHT;
    logic               ready_out, overrun, busy;

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        int lp;
        int lm;
        int g;
        int el;
        int er;
    } vec_t;

    vec_t vecs[8];

    always #5 clock = ~clock;

    block_dematrix_48 dut (
        .clock     (clock),
        .reset     (reset),
        .LpR_in    (LpR_in),
        .LpR_valid (LpR_valid),
        .LmR_in    (LmR_in),
        .LmR_valid (LmR_valid),
        .G         (G),
        .LEFT      (LEFT),
        .RIGHT     (RIGHT),
        .ready_out (ready_out),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ready_out && lat < 40);
    endtask

    int lat;
    int pulses;

    initial begin
        reset     = 1'b1;
        LpR_in    = '0;
        LmR_in    = '0;
        LpR_valid = 1'b0;
        LmR_valid = 1'b0;
        G         = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_left", LEFT, 0);
        chk("rst_right", RIGHT, 0);
        chk("rst_ready", ready_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        vecs[0] = '{lp: 1000,    lm: 200,     g: 8,  el: 1200,    er: 800};
        vecs[1] = '{lp: -131072, lm: 131071,  g: 8,  el: -1,      er: -131072};
        vecs[2] = '{lp: 5,       lm: 0,       g: 3,  el: 2,       er: 2};
        vecs[3] = '{lp: -5,      lm: 0,       g: 3,  el: -2,      er: -2};
        vecs[4] = '{lp: 1000,    lm: 200,     g: 0,  el: 0,       er: 0};
        vecs[5] = '{lp: 7,       lm: 2,       g: 1,  el: 1,       er: 1};
        vecs[6] = '{lp: -100,    lm: -50,     g: 15, el: -281,    er: -94};
        vecs[7] = '{lp: -131072, lm: -131072, g: 15, el: -131072, er: 0};

        for (int i = 0; i < 8; i++) begin
            LpR_in    = 18'(vecs[i].lp);
            LmR_in    = 18'(vecs[i].lm);
            G         = 4'(vecs[i].g);
            LpR_valid = 1'b1;
            LmR_valid = 1'b1;
            tick();
            LpR_valid = 1'b0;
            LmR_valid = 1'b0;
            chk($sformatf("vec%0d_busy_start", i), busy, 1);
            wait_ready(lat);
            chk($sformatf("vec%0d_latency", i), lat, 9);
            chk($sformatf("vec%0d_left", i), LEFT, vecs[i].el);
            chk($sformatf("vec%0d_right", i), RIGHT, vecs[i].er);
            tick();
            chk($sformatf("vec%0d_ready_width", i), ready_out, 0);
            chk($sformatf("vec%0d_busy_idle", i), busy, 0);
            chk($sformatf("vec%0d_left_hold", i), LEFT, vecs[i].el);
        end

        // Split strobes: latency runs from the LmR edge.
        G         = 4'd15;
        LpR_in    = 18'sd131071;
        LpR_valid = 1'b1;
        tick();
        LpR_valid = 1'b0;
        chk("split_busy_half", busy, 0);
        tick();
        tick();
        LmR_in    = 18'sd131071;
        LmR_valid = 1'b1;
        tick();
        LmR_valid = 1'b0;
        wait_ready(lat);
        chk("split_latency", lat, 9);
        chk("split_left", LEFT, 131071);
        chk("split_right", RIGHT, 0);
        tick();

        // Overrun on a second LpR strobe before LmR arrives.
        G         = 4'd8;
        LpR_in    = 18'sd10;
        LpR_valid = 1'b1;
        tick();
        chk("ovr_first", overrun, 0);
        LpR_in = 18'sd20;
        tick();
        LpR_valid = 1'b0;
        chk("ovr_pulse", overrun, 1);
        LmR_in    = 18'sd0;
        LmR_valid = 1'b1;
        tick();
        LmR_valid = 1'b0;
        chk("ovr_clear", overrun, 0);
        wait_ready(lat);
        chk("ovr_latency", lat, 9);
        chk("ovr_left", LEFT, 20);
        chk("ovr_right", RIGHT, 20);
        tick();

        // Second pair arrives at cycle 3 of a running computation.
        LpR_in    = 18'sd1000;
        LmR_in    = 18'sd200;
        G         = 4'd8;
        LpR_valid = 1'b1;
        LmR_valid = 1'b1;
        tick();
        LpR_valid = 1'b0;
        LmR_valid = 1'b0;
        tick();
        tick();
        LpR_in    = -18'sd100;
        LmR_in    = -18'sd50;
        G         = 4'd15;
        LpR_valid = 1'b1;
        LmR_valid = 1'b1;
        tick();
        LpR_valid = 1'b0;
        LmR_valid = 1'b0;
        chk("b2b_overrun", overrun, 0);
        wait_ready(lat);
        chk("b2b_first_latency", lat, 6);
        chk("b2b_first_left", LEFT, 1200);
        chk("b2b_first_right", RIGHT, 800);
        wait_ready(lat);
        chk("b2b_gap", lat, 10);
        chk("b2b_second_left", LEFT, -281);
        chk("b2b_second_right", RIGHT, -94);
        tick();
        chk("b2b_busy_idle", busy, 0);

        // Reset at cycle 5 aborts the pair and drops a half-captured sample.
        LpR_in    = 18'sd5;
        LmR_in    = 18'sd0;
        G         = 4'd3;
        LpR_valid = 1'b1;
        LmR_valid = 1'b1;
        tick();
        LmR_valid = 1'b0;
        LpR_in    = 18'sd77;
        tick();
        LpR_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_left", LEFT, 0);
        chk("abort_right", RIGHT, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready_out, 0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (ready_out)
                pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        LmR_in    = 18'sd0;
        LmR_valid = 1'b1;
        tick();
        LmR_valid = 1'b0;
        chk("abort_flag_cleared", busy, 0);
        LpR_in    = 18'sd5;
        LpR_valid = 1'b1;
        tick();
        LpR_valid = 1'b0;
        wait_ready(lat);
        chk("recover_latency", lat, 9);
        chk("recover_left", LEFT, 2);
        chk("recover_right", RIGHT, 2);
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
